ghr_ckpt: RTL and testbench
===========================

GHR_CKPT -- requirements
Module: ghr_ckpt

Interface
REQ-001 Parameter GHR_W, default 8: history length in bits, legal 2..64.
REQ-002 Parameter CKPT_DEPTH, default 4: in-flight branch checkpoints, power of two, legal 2..32.
REQ-003 Parameter IDX_W, default 6: folded-index width, legal 1..GHR_W.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pred_valid  in  1  a predicted branch enters the history this cycle.
REQ-007 pred_taken  in  1  predicted direction.
REQ-008 pred_ready  out  1  a checkpoint is free; high when ckpt_count < CKPT_DEPTH.
REQ-009 pred_tag  out  log2(CKPT_DEPTH)  checkpoint tag assigned to the current prediction (tail pointer).
REQ-010 res_valid  in  1  resolution of branch res_tag.
REQ-011 res_tag  in  log2(CKPT_DEPTH)  tag being resolved.
REQ-012 res_mispredict  in  1  the resolved direction differs from the prediction.
REQ-013 res_taken  in  1  actual direction.
REQ-014 commit_valid  in  1  retire the oldest checkpoint.
REQ-015 ghr_spec  out  GHR_W  speculative global history; bit 0 is the newest outcome.
REQ-016 ckpt_count  out  log2(CKPT_DEPTH)+1  number of live checkpoints.
REQ-017 ghr_fold  out  IDX_W  folded history; present only under GHR_FOLD_EN.

Function
REQ-018 The checkpoint store shall be a circular buffer with head and tail pointers; each entry holds ghr_spec as it was before its branch's shift.
REQ-019 Accepted prediction (pred_valid && pred_ready, no recovery that cycle): snap[tail] <= ghr_spec; ghr_spec <= {ghr_spec[GHR_W-2:0], pred_taken}; tail +1 with wrap; count +1, all on the next edge.
REQ-020 pred_valid while pred_ready is low shall be ignored, with no state change.
REQ-021 Recovery (res_valid && res_mispredict, res_tag live): ghr_spec <= {snap[res_tag][GHR_W-2:0], res_taken}; tail <= res_tag+1 with wrap; all younger checkpoints are discarded; count is recomputed as (res_tag - head + 1) mod CKPT_DEPTH, or CKPT_DEPTH when that result is 0.
REQ-022 A correct resolution (res_mispredict low) shall change no state.
REQ-023 A res_valid whose res_tag is not live shall be ignored.
REQ-024 Recovery shall take priority over pred_valid in the same cycle; that prediction is dropped and tagless.
REQ-025 Commit (commit_valid, count > 0): head +1 with wrap, count −1; commit at count 0 shall be ignored.
REQ-026 Commit and accepted prediction in the same cycle: count is unchanged and both pointers advance.
REQ-027 Commit and recovery in the same cycle: the commit is applied to head first, then the recovery, on the same edge.
REQ-028 When commit retires the entry named by a same-cycle recovery, the recovery shall still apply and count shall become 0.
REQ-029 All outputs shall be registered or decoded from registers only; there is no input-to-output combinational path.

Reset
REQ-030 On reset: ghr_spec = 0, head = tail = 0, ckpt_count = 0, pred_ready = 1, pred_tag = 0, ghr_fold = 0.
REQ-031 Reset shall override every concurrent prediction, resolution and commit, including mid-recovery.
REQ-032 Checkpoint contents need not be reset.

Configuration
REQ-033 With GHR_FOLD_EN defined, ghr_fold shall be the XOR of ghr_spec split into IDX_W-bit chunks from bit 0, with the last chunk zero-padded.
REQ-034 Without GHR_FOLD_EN, the ghr_fold port and its logic shall be absent; all other behaviour is identical.

Structure
REQ-035 A shared package ghr_pkg shall hold the default parameter constants and a ghr_ckpt_entry_t typedef.
REQ-036 The checkpoint buffer shall be one sub-module, ghr_ckpt_ring: storage, pointers and count.
REQ-037 Shift, recovery and fold logic shall live in ghr_ckpt.

Verification
REQ-038 Reset, then predictions T,N,T,T (defaults) -> ghr_spec = 8'b0000_1011, tags 0..3, count = 4, pred_ready = 0.
REQ-039 Full buffer with pred_valid high -> ghr_spec and count unchanged.
REQ-040 After REQ-038, resolve tag 1 as mispredict with res_taken = 1 -> ghr_spec = 8'b0000_0011, count = 2, pred_tag = 2.
REQ-041 Same-cycle recovery (tag 0, taken = 0) and pred_valid -> ghr_spec = 8'b0000_0000, count = 1, prediction dropped.
REQ-042 Commit on empty buffer, then 5 predict+commit pairs across the wrap -> count stays 0/1 correctly, pointers wrap at 4.
REQ-043 With GHR_FOLD_EN, GHR_W = 8, IDX_W = 6, ghr_spec = 8'hFF -> ghr_fold = 6'b111100.

Source files
------------

// File: rtl/ghr_pkg.sv
// Shared constants and types for the global-history checkpoint block.
// Optional fold output is enabled with the GHR_FOLD_EN macro.
package ghr_pkg;

    localparam int GHR_W_DEF      = 8;
    localparam int CKPT_DEPTH_DEF = 4;
    localparam int IDX_W_DEF      = 6;

    typedef logic [GHR_W_DEF-1:0] ghr_ckpt_entry_t;

endpackage

// File: rtl/ghr_ckpt_if.sv
// Prediction / resolution / commit bundle of the history checkpoint block.
// The ghr_fold signal exists only when GHR_FOLD_EN is defined.
interface ghr_ckpt_if
    import ghr_pkg::*;
#(
    parameter int GHR_W      = GHR_W_DEF,
    parameter int CKPT_DEPTH = CKPT_DEPTH_DEF,
    parameter int IDX_W      = IDX_W_DEF
) ();
    localparam int TAG_W = $clog2(CKPT_DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic [TAG_W-1:0] pred_tag;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_mispredict;
    logic             res_taken;
    logic             commit_valid;
    logic [GHR_W-1:0] ghr_spec;
    logic [CNT_W-1:0] ckpt_count;
`ifdef GHR_FOLD_EN
    logic [IDX_W-1:0] ghr_fold;
`endif

    modport master (
        output pred_valid, pred_taken, res_valid, res_tag, res_mispredict,
               res_taken, commit_valid,
`ifdef GHR_FOLD_EN
        input  ghr_fold,
`endif
        input  pred_ready, pred_tag, ghr_spec, ckpt_count
    );

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_tag, res_mispredict,
               res_taken, commit_valid,
`ifdef GHR_FOLD_EN
        output ghr_fold,
`endif
        output pred_ready, pred_tag, ghr_spec, ckpt_count
    );

endinterface

// File: rtl/ghr_ckpt_ring.sv
// Circular checkpoint store: snapshots of history plus head/tail/count.
// Liveness of a resolving tag is judged against the state before this edge.
module ghr_ckpt_ring #(
    parameter  int GHR_W = 8,
    parameter  int DEPTH = 4,
    localparam int TAG_W = $clog2(DEPTH),
    localparam int CNT_W = TAG_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [GHR_W-1:0] i_push_data,
    input  logic             i_commit,
    input  logic             i_recover,
    input  logic [TAG_W-1:0] i_rec_tag,
    output logic [TAG_W-1:0] o_tail,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_rec_live,
    output logic [GHR_W-1:0] o_rec_data
);
    logic [GHR_W-1:0] r_snap [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_commit_ok;
    logic [TAG_W-1:0] w_offset;
    logic [CNT_W-1:0] w_rec_count;

    assign w_commit_ok = i_commit && (r_count != CNT_W'(0));
    assign w_offset    = i_rec_tag - r_head;
    // Entries head..rec_tag survive; a same-cycle commit removes the oldest.
    assign w_rec_count = {1'b0, w_offset} + CNT_W'(1) - CNT_W'(w_commit_ok);

    assign o_tail     = r_tail;
    assign o_count    = r_count;
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_rec_live = ({1'b0, w_offset} < r_count);
    assign o_rec_data = r_snap[i_rec_tag];

    // Snapshot storage; contents are meaningful only while live, so no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_snap[r_tail] <= i_push_data;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_recover) begin
            r_head  <= r_head + TAG_W'(w_commit_ok);
            r_tail  <= i_rec_tag + TAG_W'(1);
            r_count <= w_rec_count;
        end else begin
            r_head  <= r_head + TAG_W'(w_commit_ok);
            r_tail  <= r_tail + TAG_W'(i_push);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_commit_ok);
        end
    end

endmodule

// File: rtl/ghr_ckpt.sv
// Speculative global history register with checkpoint-based recovery.
// Define GHR_FOLD_EN to add the folded-history output.
module ghr_ckpt
    import ghr_pkg::*;
#(
    parameter int GHR_W      = GHR_W_DEF,
    parameter int CKPT_DEPTH = CKPT_DEPTH_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    ghr_ckpt_if.slave  bus
);
    localparam int TAG_W = $clog2(CKPT_DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic [GHR_W-1:0] r_ghr;
    logic [TAG_W-1:0] w_tail;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_rec_live;
    logic [GHR_W-1:0] w_rec_data;
    logic             w_recover;
    logic             w_push;

    // Recovery wins over a same-cycle prediction, which is then dropped.
    assign w_recover = bus.res_valid && bus.res_mispredict && w_rec_live;
    assign w_push    = bus.pred_valid && !w_full && !w_recover;

    ghr_ckpt_ring #(
        .GHR_W (GHR_W),
        .DEPTH (CKPT_DEPTH)
    ) u_ring (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (r_ghr),
        .i_commit    (bus.commit_valid),
        .i_recover   (w_recover),
        .i_rec_tag   (bus.res_tag),
        .o_tail      (w_tail),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_rec_live  (w_rec_live),
        .o_rec_data  (w_rec_data)
    );

    // History shift on prediction, restore-and-correct on recovery.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (w_recover) begin
            r_ghr <= {w_rec_data[GHR_W-2:0], bus.res_taken};
        end else if (w_push) begin
            r_ghr <= {r_ghr[GHR_W-2:0], bus.pred_taken};
        end else begin
            r_ghr <= r_ghr;
        end
    end

    assign bus.ghr_spec   = r_ghr;
    assign bus.ckpt_count = w_count;
    assign bus.pred_ready = !w_full;
    assign bus.pred_tag   = w_tail;

`ifdef GHR_FOLD_EN
    logic [IDX_W-1:0] w_fold;

    // Bit i lands in fold position i mod IDX_W; a short last chunk pads with zeros.
    always_comb begin
        w_fold = '0;
        for (int i = 0; i < GHR_W; i++) begin
            w_fold[i % IDX_W] = w_fold[i % IDX_W] ^ r_ghr[i];
        end
    end

    assign bus.ghr_fold = w_fold;
`endif

endmodule

// File: tb/tb_ghr_ckpt.sv
// Directed plus randomized bench for ghr_ckpt against a queue-based model.
// Also exercises the fold output when GHR_FOLD_EN is defined.
module tb_ghr_ckpt;
    import ghr_pkg::*;

    localparam int GW = GHR_W_DEF;
    localparam int CD = CKPT_DEPTH_DEF;
    localparam int IW = IDX_W_DEF;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    typedef struct {
        int              tag;
        ghr_ckpt_entry_t snap;
    } ent_t;

    ent_t mq[$];
    int   m_ghr;
    int   m_next_tag;

    ghr_ckpt_if #(.GHR_W(GW), .CKPT_DEPTH(CD), .IDX_W(IW)) bus ();

    ghr_ckpt #(.GHR_W(GW), .CKPT_DEPTH(CD), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the live checkpoints are a queue ordered oldest-first.
    task automatic model_step(input bit rst, input bit pv, input bit pt, input bit rv,
                              input int rtag, input bit rm, input bit rtk, input bit cv);
        int rec_idx;
        bit commit_ok;
        ent_t e;
        if (rst) begin
            m_ghr = 0;
            mq.delete();
            m_next_tag = 0;
            return;
        end
        rec_idx = -1;
        if (rv && rm) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].tag == rtag) rec_idx = i;
            end
        end
        commit_ok = cv && (mq.size() > 0);
        if (rec_idx >= 0) begin
            m_ghr = ((int'(mq[rec_idx].snap) * 2) + int'(rtk)) % (1 << GW);
            while (mq.size() > rec_idx + 1) void'(mq.pop_back());
            m_next_tag = (rtag + 1) % CD;
            if (commit_ok) void'(mq.pop_front());
        end else begin
            if (commit_ok) void'(mq.pop_front());
            if (pv && (mq.size() + (commit_ok ? 1 : 0)) < CD) begin
                e.tag  = m_next_tag;
                e.snap = ghr_ckpt_entry_t'(m_ghr);
                mq.push_back(e);
                m_ghr = ((m_ghr * 2) + int'(pt)) % (1 << GW);
                m_next_tag = (m_next_tag + 1) % CD;
            end
        end
    endtask

    task automatic step(input bit rst, input bit pv, input bit pt, input bit rv,
                        input int rtag, input bit rm, input bit rtk, input bit cv);
        reset              = rst;
        bus.pred_valid     = pv;
        bus.pred_taken     = pt;
        bus.res_valid      = rv;
        bus.res_tag        = rtag[1:0];
        bus.res_mispredict = rm;
        bus.res_taken      = rtk;
        bus.commit_valid   = cv;
        model_step(rst, pv, pt, rv, rtag, rm, rtk, cv);
        @(posedge clk);
        #1;
        check("ghr_spec", 64'(bus.ghr_spec), 64'(m_ghr));
        check("ckpt_count", 64'(bus.ckpt_count), 64'(mq.size()));
        check("pred_ready", 64'(bus.pred_ready), 64'(mq.size() < CD));
        check("pred_tag", 64'(bus.pred_tag), 64'(m_next_tag));
`ifdef GHR_FOLD_EN
        begin
            int f;
            f = 0;
            for (int c = 0; c * IW < GW; c++) f = f ^ ((m_ghr >> (c * IW)) & ((1 << IW) - 1));
            check("ghr_fold", 64'(bus.ghr_fold), 64'(f));
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_ghr    = 0;
        m_next_tag = 0;
        reset    = 1'b1;
        bus.pred_valid = 1'b0; bus.pred_taken = 1'b0; bus.res_valid = 1'b0;
        bus.res_tag = 2'd0; bus.res_mispredict = 1'b0; bus.res_taken = 1'b0;
        bus.commit_valid = 1'b0;

        // Reset state, with concurrent activity that reset must override.
        step(1, 1, 1, 1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_ghr", 64'(bus.ghr_spec), 64'd0);
        check("reset_ready", 64'(bus.pred_ready), 64'd1);

        // Four predictions T,N,T,T fill the buffer.
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        check("fill_ghr", 64'(bus.ghr_spec), 64'h0B);
        check("fill_count", 64'(bus.ckpt_count), 64'd4);
        check("fill_ready", 64'(bus.pred_ready), 64'd0);

        // Prediction into a full buffer is ignored; correct resolution too.
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 0, 1, 0);
        check("full_ghr", 64'(bus.ghr_spec), 64'h0B);
        check("full_count", 64'(bus.ckpt_count), 64'd4);

        // Mispredict on tag 1, actually taken.
        step(0, 0, 0, 1, 1, 1, 1, 0);
        check("rec1_ghr", 64'(bus.ghr_spec), 64'h03);
        check("rec1_count", 64'(bus.ckpt_count), 64'd2);
        check("rec1_tag", 64'(bus.pred_tag), 64'd2);

        // Mispredict on a dead tag is ignored.
        step(0, 0, 0, 1, 3, 1, 0, 0);
        check("dead_count", 64'(bus.ckpt_count), 64'd2);

        // Recovery on tag 0 beats a same-cycle prediction.
        step(0, 1, 1, 1, 0, 1, 0, 0);
        check("rec0_ghr", 64'(bus.ghr_spec), 64'h00);
        check("rec0_count", 64'(bus.ckpt_count), 64'd1);
        check("rec0_tag", 64'(bus.pred_tag), 64'd1);

        // Commit on empty, then predict/commit pairs across the wrap.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("empty_commit", 64'(bus.ckpt_count), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, i[0], 0, 0, 0, 0, 0);
            check("pair_count1", 64'(bus.ckpt_count), 64'd1);
            step(0, 0, 0, 0, 0, 0, 0, 1);
            check("pair_count0", 64'(bus.ckpt_count), 64'd0);
            check("pair_tag", 64'(bus.pred_tag), 64'((i + 1) % 4));
        end

        // Simultaneous predict+commit keeps count; commit retiring the recovered entry.
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        check("pc_count", 64'(bus.ckpt_count), 64'd1);
        step(0, 0, 0, 1, 2, 1, 1, 1);
        check("retire_rec_count", 64'(bus.ckpt_count), 64'd0);
        check("retire_rec_tag", 64'(bus.pred_tag), 64'd3);

`ifdef GHR_FOLD_EN
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 0, 0, 1);
        check("fold_ff", 64'(bus.ghr_fold), 64'h3C);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 60) == 0, ($urandom % 4) != 0, $urandom % 2,
                 ($urandom % 3) == 0, int'($urandom % 4), $urandom % 2,
                 $urandom % 2, ($urandom % 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
